// File: rtl/reg_file_mp_if.sv
// Register-file access bus: one write port, NRD read ports sharing a read
// enable, plus the ready flag raised once the post-reset clear has finished.
interface reg_file_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                re;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic                ready;

  modport master (output we, wa, wd, re, ra, input  rd, ready);
  modport slave  (input  we, wa, wd, re, ra, output rd, ready);
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file: one write port, NRD registered read ports
// with same-cycle write bypass, optional hard-wired zero register, clear-on-reset.
module reg_file_mp_lane #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic [AW-1:0]   i_ra,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [XLEN-1:0] i_rf,
  output logic [XLEN-1:0] o_rd
);
  logic [XLEN-1:0] r_rd;

  // Zero register wins over bypass so a dropped write to r0 never leaks through.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                             r_rd <= '0;
    else if (i_en) begin
      if ((ZERO_R0 != 0) && (i_ra == '0))     r_rd <= '0;
      else if (i_we && (i_wa == i_ra))       r_rd <= i_wd;
      else                                    r_rd <= i_rf;
    end
  end

  assign o_rd = r_rd;
endmodule

module reg_file_mp #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  reg_file_mp_if.slave  bus
);
  localparam int NREG = 1 << AW;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                      r_state, w_state_nxt;
  logic [AW:0]                 r_clr_cnt, w_clr_cnt_nxt;
  logic                        r_ready, w_ready_nxt;
  logic [XLEN-1:0]             r_rf [NREG];
  logic                        w_run_wr;
  logic                        w_rd_en;
  logic [NRD-1:0][AW-1:0]      w_ra;
  logic [NRD-1:0][XLEN-1:0]    w_rd;

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_ready_nxt   = r_ready;
    case (r_state)
      S_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt[AW-1:0] == {AW{1'b1}}) begin
          w_state_nxt = S_RUN;
          w_ready_nxt = 1'b1;
        end
      end
      S_RUN:   ;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign w_run_wr = bus.we && !((ZERO_R0 != 0) && (bus.wa == '0));
  assign w_rd_en  = (r_state == S_RUN) && bus.re;

  // Storage has no reset of its own; the clear walk defines every entry.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (r_state == S_CLEAR)  r_rf[r_clr_cnt[AW-1:0]] <= '0;
      else if (w_run_wr)       r_rf[bus.wa]            <= bus.wd;
    end
  end

  assign w_ra = bus.ra;

  for (genvar g = 0; g < NRD; g++) begin : g_lane
    reg_file_mp_lane #(.XLEN(XLEN), .AW(AW), .ZERO_R0(ZERO_R0)) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_rd_en),
      .i_ra    (w_ra[g]),
      .i_we    (bus.we),
      .i_wa    (bus.wa),
      .i_wd    (bus.wd),
      .i_rf    (r_rf[w_ra[g]]),
      .o_rd    (w_rd[g])
    );
  end

  assign bus.rd    = w_rd;
  assign bus.ready = r_ready;
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed test-plan steps plus random traffic checked
// against an array-based model, for ZERO_R0=1/0 and a 64-bit 3-port build.
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst64_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_mp_if #(.XLEN(32), .AW(5), .NRD(2)) ba ();
  reg_file_mp_if #(.XLEN(32), .AW(5), .NRD(2)) bz ();
  reg_file_mp_if #(.XLEN(64), .AW(4), .NRD(3)) bw ();

  assign bz.we = ba.we;
  assign bz.wa = ba.wa;
  assign bz.wd = ba.wd;
  assign bz.re = ba.re;
  assign bz.ra = ba.ra;

  reg_file_mp #(.XLEN(32), .AW(5), .NRD(2), .ZERO_R0(1)) u_a (.i_clk(clk), .i_rst_n(rst_n),   .bus(ba));
  reg_file_mp #(.XLEN(32), .AW(5), .NRD(2), .ZERO_R0(0)) u_z (.i_clk(clk), .i_rst_n(rst_n),   .bus(bz));
  reg_file_mp #(.XLEN(64), .AW(4), .NRD(3), .ZERO_R0(1)) u_w (.i_clk(clk), .i_rst_n(rst64_n), .bus(bw));

  int n_pass = 0;
  int n_tot  = 0;

  // Reference: plain arrays, edges-left-to-clear counter, expected lane values.
  logic [31:0] ma [32];
  logic [31:0] mz [32];
  logic [31:0] ea [2];
  logic [31:0] ez [2];
  int          clr_left = 32;
  logic        m_ready  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    logic [4:0] a;
    @(posedge clk);
    if (!rst_n) begin
      ea = '{32'h0, 32'h0};
      ez = '{32'h0, 32'h0};
      clr_left = 32;
      m_ready  = 1'b0;
    end else if (clr_left > 0) begin
      ma[32 - clr_left] = 32'h0;
      mz[32 - clr_left] = 32'h0;
      clr_left--;
      m_ready = (clr_left == 0);
    end else begin
      if (ba.re) begin
        for (int p = 0; p < 2; p++) begin
          a = ba.ra[p*5 +: 5];
          if (a == 5'd0)                    ea[p] = 32'h0;
          else if (ba.we && ba.wa == a)     ea[p] = ba.wd;
          else                              ea[p] = ma[a];
          ez[p] = (ba.we && ba.wa == a) ? ba.wd : mz[a];
        end
      end
      if (ba.we) begin
        if (ba.wa != 5'd0) ma[ba.wa] = ba.wd;
        mz[ba.wa] = ba.wd;
      end
    end
    #1;
    chk("model_ready_a", 64'(ba.ready), 64'(m_ready));
    chk("model_ready_z", 64'(bz.ready), 64'(m_ready));
    for (int p = 0; p < 2; p++) begin
      chk("model_rd_a", 64'(ba.rd[p*32 +: 32]), 64'(ea[p]));
      chk("model_rd_z", 64'(bz.rd[p*32 +: 32]), 64'(ez[p]));
    end
  endtask

  task automatic rand_in();
    ba.we = 1'($urandom);
    ba.wa = 5'($urandom);
    ba.wd = $urandom;
    ba.re = ($urandom_range(0, 3) != 0);
    ba.ra = 10'($urandom);
    if ($urandom_range(0, 3) == 0) ba.ra[4:0] = ba.wa;
    if ($urandom_range(0, 7) == 0) ba.ra[9:5] = 5'd0;
  endtask

  initial begin
    logic [63:0] v [3];
    logic [3:0]  wadr [3];

    ba.we = 1'b0; ba.wa = '0; ba.wd = '0; ba.re = 1'b0; ba.ra = '0;
    bw.we = 1'b0; bw.wa = '0; bw.wd = '0; bw.re = 1'b0; bw.ra = '0;

    // Reset then the 32-edge clear walk
    rst_n = 1'b0;
    step(); step();
    chk("rst_ready", 64'(ba.ready), 64'd0);
    chk("rst_rd", 64'(ba.rd), 64'd0);
    rst_n = 1'b1;
    ba.we = 1'b1; ba.wa = 5'd3; ba.wd = 32'hCAFE0003; ba.re = 1'b1; ba.ra = {5'd3, 5'd3};
    for (int i = 1; i <= 32; i++) begin
      step();
      chk("clr_ready", 64'(ba.ready), 64'(i == 32));
      if (i < 32) chk("clr_rd_zero", 64'(ba.rd), 64'd0);
    end
    ba.we = 1'b0;

    for (int a = 0; a < 32; a++) begin
      ba.ra = {5'(31 - a), 5'(a)};
      step();
      chk("clear_read0", 64'(ba.rd), 64'd0);
    end

    // Write then read
    ba.we = 1'b1; ba.wa = 5'd5; ba.wd = 32'hDEADBEEF; ba.re = 1'b0;
    step();
    ba.we = 1'b0; ba.re = 1'b1; ba.ra = {5'd6, 5'd5};
    step();
    chk("wr_rd0", 64'(ba.rd[31:0]),  64'hDEADBEEF);
    chk("wr_rd1", 64'(ba.rd[63:32]), 64'h0);

    // Bypass over a distinct old value
    ba.we = 1'b1; ba.wa = 5'd7; ba.wd = 32'hAAAA5555; ba.re = 1'b0;
    step();
    ba.wd = 32'h12345678; ba.re = 1'b1; ba.ra = {5'd7, 5'd7};
    step();
    chk("byp_rd0", 64'(ba.rd[31:0]),  64'h12345678);
    chk("byp_rd1", 64'(ba.rd[63:32]), 64'h12345678);

    // Zero register, same-cycle and following read
    ba.wa = 5'd0; ba.wd = 32'hFFFFFFFF; ba.ra = {5'd0, 5'd0};
    step();
    chk("r0_byp_a", 64'(ba.rd), 64'd0);
    chk("r0_byp_z", 64'(bz.rd), {32'hFFFFFFFF, 32'hFFFFFFFF});
    ba.we = 1'b0;
    step();
    chk("r0_rd_a", 64'(ba.rd[31:0]), 64'h0);
    chk("r0_rd_z", 64'(bz.rd[31:0]), 64'hFFFFFFFF);

    // Hold with re=0 while the held address is rewritten
    ba.ra = {5'd5, 5'd5};
    step();
    ba.re = 1'b0; ba.ra = {5'd9, 5'd3}; ba.we = 1'b1; ba.wa = 5'd5; ba.wd = 32'h0BADF00D;
    step(); step();
    chk("hold_rd0", 64'(ba.rd[31:0]),  64'hDEADBEEF);
    chk("hold_rd1", 64'(ba.rd[63:32]), 64'hDEADBEEF);
    ba.we = 1'b0;

    for (int i = 0; i < 200; i++) begin
      rand_in();
      step();
    end

    // Reset mid-traffic; traffic during the clear must be ignored
    rst_n = 1'b0;
    step();
    chk("mid_rst_rd", 64'(ba.rd), 64'd0);
    chk("mid_rst_ready", 64'(ba.ready), 64'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      rand_in();
      step();
    end
    chk("mid_rst_ready_back", 64'(ba.ready), 64'd1);
    ba.we = 1'b0; ba.re = 1'b1; ba.ra = {5'd5, 5'd5};
    step();
    chk("mid_rst_addr5", 64'(ba.rd), 64'd0);
    chk("mid_rst_addr5_z", 64'(bz.rd), 64'd0);

    for (int i = 0; i < 150; i++) begin
      rand_in();
      step();
    end

    // 64-bit, 16-entry, 3-port build
    rst64_n = 1'b0;
    @(posedge clk); #1;
    chk("w_rst_ready", 64'(bw.ready), 64'd0);
    rst64_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      chk("w_clr_ready", 64'(bw.ready), 64'(i == 16));
    end
    wadr = '{4'd3, 4'd9, 4'd14};
    for (int k = 0; k < 3; k++) begin
      v[k] = {$urandom, $urandom};
      bw.we = 1'b1; bw.wa = wadr[k]; bw.wd = v[k];
      @(posedge clk); #1;
    end
    bw.we = 1'b0; bw.re = 1'b1; bw.ra = {4'd14, 4'd9, 4'd3};
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk("w_rd", bw.rd[k*64 +: 64], v[k]);
    bw.ra = {4'd3, 4'd1, 4'd14};
    @(posedge clk); #1;
    chk("w_rd_p0", bw.rd[63:0],    v[2]);
    chk("w_rd_p1", bw.rd[127:64],  64'h0);
    chk("w_rd_p2", bw.rd[191:128], v[0]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the RISC-V cores: one synchronous write port, `NRD` synchronous read ports with write-to-read bypass, and an optional hard-wired zero register. After reset it clears the array with a clear state machine, then signals `ready`. It replaces the fixed 32x32 two-read-port register file in the decode stage of single-cycle and pipelined datapaths. Reads and writes may occur in the same cycle.

## Interface
- `XLEN`, 32: register width in bits.
- `AW`, 5: address width; depth `NREG = 1 << AW`.
- `NRD`, 2: number of read ports, 1..4.
- `ZERO_R0`, 1: 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary register.

- `clk`  in  1  clock, all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `we`  in  1  write enable.
- `wa`  in  AW  write address.
- `wd`  in  XLEN  write data.
- `re`  in  1  read enable, common to all read ports.
- `ra`  in  NRD*AW  read addresses; port i is `ra[i*AW +: AW]`.
- `rd`  out  NRD*XLEN  registered read data; port i is `rd[i*XLEN +: XLEN]`.
- `ready`  out  1  high when the array is cleared and accepting traffic.

## Operation
- States:
  - CLEAR: `clr_cnt` of AW+1 bits walks addresses 0..NREG-1 and writes 0 to one entry per cycle.
  - RUN: normal traffic.
- Reset (`rst_n`=0 at an edge):
  - state <= CLEAR, `clr_cnt` <= 0, all `rd` lanes <= 0, `ready` <= 0.
  - Array contents are undefined until CLEAR completes.
- CLEAR:
  - Each edge with `rst_n`=1 writes `rf[clr_cnt]` <= 0 and increments `clr_cnt`.
  - On the edge that clears address NREG-1: state <= RUN, `ready` <= 1.
  - `we` and `re` are ignored; `rd` stays 0.
- RUN write:
  - `we`=1 at an edge: `rf[wa]` <= `wd`.
  - Exception: when `ZERO_R0`=1 and `wa`=0, the write is dropped.
- RUN read, when `re`=1 at an edge. Each port i independently loads, in priority order:
  1. 0 if `ZERO_R0`=1 and `ra_i`=0.
  2. else `wd` if `we`=1 and `wa`=`ra_i` (bypass: same-cycle write is visible).
  3. else `rf[ra_i]`.
- `re`=0: all `rd` lanes hold their value. A write still proceeds.
- Read ports may share an address. Every matching port gets the same value.
- No arithmetic. Addresses are used as given, so all NREG entries are valid; no out-of-range case exists.

## Timing
- Let E1 be the first rising edge with `rst_n`=1 after reset.
  - Edges E1..E_NREG clear addresses 0..NREG-1.
  - `ready` is 1 after E_NREG.
  - First accepted write/read is at E_(NREG+1).
- Read latency is 1 cycle. `ra` is sampled at edge k and `rd` is valid after edge k until the next edge with `re`=1.
- Write latency is 1 cycle. Data written at edge k is in the array after k, and bypass makes it visible to a read sampled at k.
- Reset mid-CLEAR or mid-RUN follows the reset rules and restarts CLEAR from address 0. Every register reads 0 afterwards.
- `rst_n`=0 takes priority over every other input at the same edge.

## Test plan
- Default parameters, `rst_n` low 2 cycles then high:
  - `ready` is 0 through E31 and 1 after E32.
  - With `re`=1, reading all 32 addresses returns 0.
- Write then read:
  - Write `wa`=5, `wd`=0xDEADBEEF.
  - Next cycle read `ra0`=5, `ra1`=6: `rd0`=0xDEADBEEF, `rd1`=0.
- Bypass:
  - Same edge: `we`=1, `wa`=7, `wd`=0x12345678, `re`=1, `ra0`=`ra1`=7.
  - Both lanes = 0x12345678 after the edge.
  - Old contents of address 7 never appear.
- Zero register:
  - With `ZERO_R0`=1, write 0xFFFFFFFF to address 0, including in the same cycle as a read of 0: `rd`=0.
  - With `ZERO_R0`=0, the same sequence returns 0xFFFFFFFF.
- Hold and reset:
  - With `re`=0, change `ra` and write to the held address: `rd` unchanged.
  - Assert `rst_n`=0 for 1 cycle mid-traffic: `rd`=0 and `ready`=0 immediately. `ready` returns after NREG edges, and address 5 then reads 0.
- Parameter sweep, `XLEN`=64, `AW`=4, `NRD`=3:
  - `ready` after 16 edges.
  - Three ports reading distinct addresses return independent 64-bit values.
